// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement buffer for the out-of-order core. Dispatch allocates one
// entry per instruction at the tail and receives the entry index, which the
// rename table records as the pending producer. The writeback bus marks
// entries done and stores their result. The head entry retires to the rename
// table/regfile as soon as it is done, one entry per cycle. When a
// mispredicted branch retires, the buffer spends one FLUSH cycle pulsing
// `rollback` with the redirect PC and then restarts empty.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   alloc_valid/ready          dispatch handshake
//   alloc_has_dst, alloc_rd    destination of the dispatching instruction
//   alloc_index                entry handed to the dispatching instruction
//   wb_valid, wb_index,
//   wb_data, wb_mispredict,
//   wb_target                  writeback bus (result, branch outcome)
//   rd_index1/2                operand lookups for pending sources
//   rd_ready1/2, rd_data1/2    looked-up entry done and its stored result
//   commit_valid, commit_we,
//   commit_addr, commit_data,
//   commit_index               head entry retiring this cycle
//   rollback, rollback_pc      one-cycle flush pulse and redirect PC
//   count                      occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ENTRY_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic                   alloc_has_dst,
  input  logic [4:0]             alloc_rd,
  output logic [ENTRY_WIDTH-1:0] alloc_index,
  input  logic                   wb_valid,
  input  logic [ENTRY_WIDTH-1:0] wb_index,
  input  logic [31:0]            wb_data,
  input  logic                   wb_mispredict,
  input  logic [31:0]            wb_target,
  input  logic [ENTRY_WIDTH-1:0] rd_index1,
  input  logic [ENTRY_WIDTH-1:0] rd_index2,
  output logic                   rd_ready1,
  output logic                   rd_ready2,
  output logic [31:0]            rd_data1,
  output logic [31:0]            rd_data2,
  output logic                   commit_valid,
  output logic                   commit_we,
  output logic [4:0]             commit_addr,
  output logic [31:0]            commit_data,
  output logic [ENTRY_WIDTH-1:0] commit_index,
  output logic                   rollback,
  output logic [31:0]            rollback_pc,
  output logic [ENTRY_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ENTRY_WIDTH;
  localparam logic [ENTRY_WIDTH:0] DEPTH_CNT = DEPTH[ENTRY_WIDTH:0];

  typedef enum logic {RUN, FLUSH} state_e;

  state_e state_q, state_d;

  // Control state: reset and flushed.
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       done_q;
  logic [ENTRY_WIDTH-1:0] head_q;
  logic [ENTRY_WIDTH-1:0] tail_q;
  logic [ENTRY_WIDTH:0]   count_q;
  logic [31:0]            rollback_pc_q;

  // Payload state: only ever observed through a set valid/done bit.
  logic [DEPTH-1:0]       mispredict_q;
  logic [DEPTH-1:0]       has_dst_q;
  logic [4:0]             rd_q     [DEPTH];
  logic [31:0]            data_q   [DEPTH];
  logic [31:0]            target_q [DEPTH];

  logic head_commit;
  logic head_mispredict;
  logic alloc_fire;
  logic wb_fire;

  // Next-state logic; also decides whether the head retires this cycle.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    head_commit     = 1'b0;
    head_mispredict = 1'b0;
    case (state_q)
      RUN: begin
        head_commit     = valid_q[head_q] & done_q[head_q];
        head_mispredict = head_commit & mispredict_q[head_q];
        if (head_mispredict) state_d = FLUSH;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Space freed by a same-cycle commit is not reusable until the next cycle,
  // and nothing is accepted while a mispredict retires (it is about to be
  // flushed anyway).
  assign alloc_ready = (state_q == RUN) && (count_q < DEPTH_CNT) && !head_mispredict;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign wb_fire     = (state_q == RUN) & wb_valid & valid_q[wb_index];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      valid_q       <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rollback_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH) begin
        valid_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (wb_fire) done_q[wb_index] <= 1'b1;
        if (alloc_fire) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        // Placed last so retiring clears the entry even if a stale writeback
        // targets the head in the same cycle.
        if (head_commit) begin
          valid_q[head_q] <= 1'b0;
          done_q[head_q]  <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        if (head_mispredict) rollback_pc_q <= target_q[head_q];
        count_q <= count_q + (ENTRY_WIDTH+1)'(alloc_fire) - (ENTRY_WIDTH+1)'(head_commit);
      end
    end
  end

  // NOTE: the payload arrays are deliberately not reset; every output built
  // from them is gated by a reset valid/done bit, so their contents never
  // leak out before being written.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_dst_q[tail_q]    <= alloc_has_dst;
      rd_q[tail_q]         <= alloc_rd;
      mispredict_q[tail_q] <= 1'b0;
    end
    if (wb_fire) begin
      data_q[wb_index]       <= wb_data;
      mispredict_q[wb_index] <= wb_mispredict;
      target_q[wb_index]     <= wb_target;
    end
  end

  assign alloc_index = tail_q;
  assign count       = count_q;

  assign commit_valid = head_commit;
  assign commit_we    = head_commit & has_dst_q[head_q] & (rd_q[head_q] != 5'd0);
  assign commit_addr  = head_commit ? rd_q[head_q]   : '0;
  assign commit_data  = head_commit ? data_q[head_q] : '0;
  assign commit_index = head_commit ? head_q         : '0;

  assign rollback    = (state_q == FLUSH);
  assign rollback_pc = rollback ? rollback_pc_q : '0;

  // Lookups see registered state only; a same-cycle writeback is not bypassed.
  assign rd_ready1 = valid_q[rd_index1] & done_q[rd_index1];
  assign rd_ready2 = valid_q[rd_index2] & done_q[rd_index2];
  assign rd_data1  = rd_ready1 ? data_q[rd_index1] : '0;
  assign rd_data2  = rd_ready2 ? data_q[rd_index2] : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer. Stimulus pushes the commit/rollback it
// expects into scoreboard queues; a negedge monitor pops and compares each
// time the DUT retires an entry or pulses rollback. Direct checks cover
// handshake, occupancy, lookups and reset values.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  idx;
    logic        we;
  } commit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_has_dst;
  logic [4:0]  alloc_rd;
  logic [2:0]  alloc_index;
  logic        wb_valid, wb_mispredict;
  logic [2:0]  wb_index;
  logic [31:0] wb_data, wb_target;
  logic [2:0]  rd_index1, rd_index2;
  logic        rd_ready1, rd_ready2;
  logic [31:0] rd_data1, rd_data2;
  logic        commit_valid, commit_we;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  commit_index;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic [3:0]  count;

  commit_t     exp_q[$];
  logic [31:0] rb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;

  reorder_buffer #(.ENTRY_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dst(alloc_has_dst), .alloc_rd(alloc_rd), .alloc_index(alloc_index),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .rd_index1(rd_index1), .rd_index2(rd_index2),
    .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_index(commit_index),
    .rollback(rollback), .rollback_pc(rollback_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_commit(input logic [4:0] addr, input logic [31:0] data,
                             input logic [2:0] idx, input logic we);
    commit_t c;
    c.addr = addr; c.data = data; c.idx = idx; c.we = we;
    exp_q.push_back(c);
  endtask

  task automatic alloc(input logic [4:0] rd, input logic has_dst, input logic [2:0] exp_idx);
    alloc_valid   = 1'b1;
    alloc_rd      = rd;
    alloc_has_dst = has_dst;
    #1;
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    check("alloc_index", 32'(alloc_index), 32'(exp_idx));
    cyc();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] idx, input logic [31:0] data,
                    input logic mp, input logic [31:0] tgt);
    wb_valid      = 1'b1;
    wb_index      = idx;
    wb_data       = data;
    wb_mispredict = mp;
    wb_target     = tgt;
    cyc();
    wb_valid      = 1'b0;
    wb_mispredict = 1'b0;
  endtask

  // Bounded wait for every expected commit to appear.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alloc_ready"},  32'(alloc_ready),  32'd1);
    check({tag, "_alloc_index"},  32'(alloc_index),  32'd0);
    check({tag, "_count"},        32'(count),        32'd0);
    check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
    check({tag, "_commit_we"},    32'(commit_we),    32'd0);
    check({tag, "_commit_addr"},  32'(commit_addr),  32'd0);
    check({tag, "_commit_data"},  commit_data,       32'd0);
    check({tag, "_commit_index"}, 32'(commit_index), 32'd0);
    check({tag, "_rollback"},     32'(rollback),     32'd0);
    check({tag, "_rollback_pc"},  rollback_pc,       32'd0);
    check({tag, "_rd_ready1"},    32'(rd_ready1),    32'd0);
    check({tag, "_rd_data1"},     rd_data1,          32'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got index %0d data 0x%0h, none expected",
                   commit_index, commit_data);
        end else begin
          commit_t c;
          c = exp_q.pop_front();
          check("commit_addr",  32'(commit_addr),  32'(c.addr));
          check("commit_data",  commit_data,       c.data);
          check("commit_index", 32'(commit_index), 32'(c.idx));
          check("commit_we",    32'(commit_we),    32'(c.we));
        end
      end
      if (rollback) begin
        if (rb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rollback: got pc 0x%0h, none expected", rollback_pc);
        end else begin
          logic [31:0] pc;
          pc = rb_q.pop_front();
          check("rollback_pc", rollback_pc, pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_has_dst = 1'b0; alloc_rd = '0;
    wb_valid = 1'b0; wb_index = '0; wb_data = '0; wb_mispredict = 1'b0; wb_target = '0;
    rd_index1 = '0; rd_index2 = '0;
    repeat (2) cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check_reset_outputs("reset");

    // In-order commit of out-of-order results.
    push_commit(5'd1, 32'hB, 3'd0, 1'b1);
    push_commit(5'd2, 32'hC, 3'd1, 1'b1);
    push_commit(5'd3, 32'hA, 3'd2, 1'b1);
    alloc(5'd1, 1'b1, 3'd0);
    alloc(5'd2, 1'b1, 3'd1);
    alloc(5'd3, 1'b1, 3'd2);
    check("count_after_3", 32'(count), 32'd3);
    rd_index1 = 3'd2;
    rd_index2 = 3'd0;
    #1;
    check("rd_ready_before_wb", 32'(rd_ready1), 32'd0);
    wb(3'd2, 32'hA, 1'b0, 32'h0);
    check("rd_ready1_idx2", 32'(rd_ready1), 32'd1);
    check("rd_data1_idx2",  rd_data1,       32'hA);
    check("rd_ready2_idx0", 32'(rd_ready2), 32'd0);
    wb(3'd0, 32'hB, 1'b0, 32'h0);
    wb(3'd1, 32'hC, 1'b0, 32'h0);
    drain("inorder_drained");
    check("count_after_drain", 32'(count), 32'd0);

    // Destination x0 retires without a regfile write.
    push_commit(5'd0, 32'h55, 3'd3, 1'b0);
    alloc(5'd0, 1'b1, 3'd3);
    wb(3'd3, 32'h55, 1'b0, 32'h0);
    drain("rd0_drained");

    // Restart from index 0 and fill the buffer.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) alloc(5'(i + 8), 1'b1, 3'(i));
    #1;
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_count",       32'(count),       32'd8);

    // Commit and allocate in the same cycle: refused, accepted next cycle.
    push_commit(5'd8, 32'h100, 3'd0, 1'b1);
    wb(3'd0, 32'h100, 1'b0, 32'h0);
    alloc_valid = 1'b1; alloc_rd = 5'd20; alloc_has_dst = 1'b1;
    #1;
    check("full_commit_alloc_ready", 32'(alloc_ready), 32'd0);
    cyc();
    #1;
    check("after_commit_alloc_ready", 32'(alloc_ready), 32'd1);
    check("after_commit_alloc_index", 32'(alloc_index), 32'd0);
    check("after_commit_count",       32'(count),       32'd7);
    cyc();
    alloc_valid = 1'b0;
    check("refill_count", 32'(count), 32'd8);

    // Mispredicting entry 1 retires, then rollback; entries 2..7,0 are lost.
    push_commit(5'd9, 32'h11, 3'd1, 1'b1);
    rb_q.push_back(32'h80);
    wb(3'd1, 32'h11, 1'b1, 32'h80);
    #1;
    check("mp_commit_alloc_ready", 32'(alloc_ready), 32'd0);
    cyc();
    check("flush_rollback", 32'(rollback), 32'd1);
    check("flush_pc",       rollback_pc,   32'h80);
    wb(3'd2, 32'h22, 1'b0, 32'h0);  // ignored: arrives during FLUSH
    check("post_flush_count",       32'(count),       32'd0);
    check("post_flush_alloc_index", 32'(alloc_index), 32'd0);
    check("post_flush_alloc_ready", 32'(alloc_ready), 32'd1);
    check("post_flush_rollback",    32'(rollback),    32'd0);
    rd_index1 = 3'd2;
    #1;
    check("post_flush_rd_ready_idx2", 32'(rd_ready1), 32'd0);

    // Writeback to an unallocated entry is dropped.
    wb(3'd5, 32'hDEAD, 1'b0, 32'h0);
    check("stray_wb_count", 32'(count), 32'd0);
    for (int i = 0; i < 6; i++) alloc(5'(i + 7), 1'b1, 3'(i));
    rd_index1 = 3'd5;
    #1;
    check("stray_wb_rd_ready", 32'(rd_ready1), 32'd0);
    check("stray_wb_rd_data",  rd_data1,       32'd0);
    check("stray_wb_commit",   32'(commit_valid), 32'd0);

    // Reset asserted in the FLUSH cycle wins.
    push_commit(5'd7, 32'h1, 3'd0, 1'b1);
    rb_q.push_back(32'h200);
    wb(3'd0, 32'h1, 1'b1, 32'h200);
    cyc();
    rst = 1'b1;
    #1;
    check("rst_flush_rollback", 32'(rollback), 32'd1);
    cyc();
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_in_flush");

    repeat (3) cyc();
    check("commit_queue_empty",   32'(exp_q.size()), 32'd0);
    check("rollback_queue_empty", 32'(rb_q.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core. Allocates one entry per dispatched instruction and returns the entry index that the rename table records as the pending producer. Captures results from the writeback bus and commits completed entries in program order to the rename table/regfile. On a committed mispredicted branch, emits a one-cycle `rollback` with the redirect PC and flushes all entries.

## Interface
- `ENTRY_WIDTH`, 3: entry index width; DEPTH = 2**ENTRY_WIDTH (8).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `alloc_valid` in 1: dispatch requests an entry.
- `alloc_ready` out 1: entry can be accepted this cycle.
- `alloc_has_dst` in 1: instruction writes a register.
- `alloc_rd` in 5: destination register.
- `alloc_index` out ENTRY_WIDTH: index given to the allocating instruction (tail pointer).
- `wb_valid` in 1: writeback bus carries a result.
- `wb_index` in ENTRY_WIDTH: entry being completed.
- `wb_data` in 32: result value.
- `wb_mispredict` in 1: entry is a mispredicted control transfer.
- `wb_target` in 32: correct PC when `wb_mispredict`=1.
- `rd_index1`, `rd_index2` in ENTRY_WIDTH: operand lookups for pending sources.
- `rd_ready1`, `rd_ready2` out 1: looked-up entry is valid and done.
- `rd_data1`, `rd_data2` out 32: stored result of the looked-up entry.
- `commit_valid` out 1: head entry retires this cycle.
- `commit_we` out 1: retiring entry writes the regfile (has_dst and rd≠0).
- `commit_addr` out 5, `commit_data` out 32, `commit_index` out ENTRY_WIDTH: retiring entry's rd, result and index.
- `rollback` out 1: flush pulse to the rename table and front end.
- `rollback_pc` out 32: redirect PC, valid while `rollback`=1.
- `count` out ENTRY_WIDTH+1: occupied entries.

## Operation
- Per-entry state: valid, done, mispredict, has_dst, rd[4:0], data[31:0], target[31:0]. Pointers: head, tail (ENTRY_WIDTH bits, wrap mod DEPTH), count.
- FSM states: RUN, FLUSH.
- Allocation (RUN): when `alloc_valid & alloc_ready`, entry[tail] ← valid=1, done=0, mispredict=0, has_dst, rd. Then tail+1 and count+1.
- `alloc_ready` = (state==RUN) & (count<DEPTH) & ~(mispredict commit this cycle). A same-cycle commit does not free space for a same-cycle allocation.
- Writeback: when `wb_valid` and entry[wb_index].valid=1, set done=1 and write data, mispredict and target.
  - Writeback to an invalid entry is ignored.
  - Writeback during FLUSH is ignored.
- Commit (RUN): `commit_valid` = entry[head].valid & done. On commit: entry cleared, head+1, count−1. At most one commit per cycle.
- A mispredicting head commits normally (its result is written), and the FSM moves to FLUSH.
- FLUSH (exactly one cycle):
  - `rollback`=1 and `rollback_pc` = captured target.
  - All valid bits cleared; head=tail=count=0.
  - Inputs ignored, `commit_valid`=0.
  - Then return to RUN.
- Simultaneous alloc+commit: count unchanged, both pointers advance.
- Read ports are combinational from registered state. A writeback in the same cycle is not forwarded.

## Timing
- Reset: all entry valid=0; head=tail=count=0; state=RUN.
  - Outputs after reset: `alloc_ready`=1, `alloc_index`=0.
  - `commit_valid`, `commit_we`, `rollback`, `rd_ready*`=0; `commit_addr`, `commit_data`, `commit_index`, `rollback_pc`, `rd_data*`=0.
- `rst` has priority over every other input, including during FLUSH.
- Writeback to commit: minimum 1 cycle. A result written at edge N is committed in cycle N+1 if its entry is at head.
- Commit outputs are combinational from head state. The rename table samples them at the same edge that advances head.
- Mispredict: commit in cycle C, `rollback` high in cycle C+1 only, allocation resumes in cycle C+2 with `alloc_index`=0.
- Full: `alloc_ready`=0 at count==DEPTH. Tail wraps from DEPTH−1 to 0.

## Test plan
- Reset, then allocate 3 entries (rd=1,2,3) → `alloc_index` 0,1,2; count=3. Write back indices 2,0,1 with data 0xA,0xB,0xC → commits in order: (rd1,0xB,idx0), (rd2,0xC,idx1), (rd3,0xA,idx2), one per cycle.
- Fill 8 entries → `alloc_ready`=0 and count=8. Commit head and allocate in the same cycle → allocation refused that cycle, accepted next with `alloc_index`=0 (wrap).
- Entry with has_dst=1, rd=0 completes → `commit_valid`=1, `commit_we`=0.
- Entry 1 written back with mispredict, target 0x80 while entries 2–4 are pending → entry 1 commits, next cycle `rollback`=1 with `rollback_pc`=0x80, then count=0, `alloc_index`=0, entries 2–4 never commit.
- Writeback to an unallocated index 5 → no state change. `rd_ready` on index 5 stays 0.
- Assert `rst` during the FLUSH cycle → next cycle all outputs are at reset values and `rollback`=0.
